// File: rtl/pwm_shadow_loader.sv
// Double-buffered period/compare1/compare2 shadows, committed to the PWM register file as a
// byte-write burst that only uses bus cycles the host leaves idle.
// Optional build macro PWM_SHADOW_SYNC_WRAP_EN: hold the burst until counter_val reaches zero.
module pwm_shadow_loader #(
    parameter logic [5:0] PERIOD_ADDR = 6'h00,
    parameter logic [5:0] CMP1_ADDR   = 6'h03,
    parameter logic [5:0] CMP2_ADDR   = 6'h05
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_read,
    input  logic        h_write,
    input  logic [5:0]  h_addr,
    input  logic [7:0]  h_data_write,
    output logic [7:0]  h_data_read,
    output logic        read,
    output logic        write,
    output logic [5:0]  addr,
    output logic [7:0]  data_write,
    input  logic [7:0]  data_read,
    input  logic        sh_wr,
    input  logic [1:0]  sh_sel,
    input  logic [15:0] sh_data,
    input  logic        commit,
    input  logic [15:0] counter_val,
    output logic        busy,
    output logic        done
);

`ifdef PWM_SHADOW_SYNC_WRAP_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ARMED = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [15:0] sh_period;
    logic [15:0] sh_cmp1;
    logic [15:0] sh_cmp2;
    logic [2:0]  dirty;
    logic [2:0]  dirty_nxt;
    logic        byte_hi;

    logic        host_act;
    logic        shadow_ld;
    logic [2:0]  ld_mask;
    logic [2:0]  cur_mask;
    logic [5:0]  cur_base;
    logic [15:0] cur_value;
    logic [5:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        loader_req;
    logic        grant;

`ifndef PWM_SHADOW_SYNC_WRAP_EN
    logic unused_counter_val;
    assign unused_counter_val = ^counter_val;
`endif

    assign host_act  = h_read | h_write;
    assign shadow_ld = sh_wr && (state == S_IDLE) && (sh_sel != 2'd3);

    always_comb begin
        ld_mask = '0;
        case (sh_sel)
            2'd0:    ld_mask = 3'b001;
            2'd1:    ld_mask = 3'b010;
            2'd2:    ld_mask = 3'b100;
            default: ld_mask = '0;
        endcase
    end

    // Lowest dirty register is the one being written; this yields period, cmp1, cmp2 order.
    always_comb begin
        cur_mask  = 3'b001;
        cur_base  = PERIOD_ADDR;
        cur_value = sh_period;
        if (dirty[0]) begin
            cur_mask  = 3'b001;
            cur_base  = PERIOD_ADDR;
            cur_value = sh_period;
        end else if (dirty[1]) begin
            cur_mask  = 3'b010;
            cur_base  = CMP1_ADDR;
            cur_value = sh_cmp1;
        end else if (dirty[2]) begin
            cur_mask  = 3'b100;
            cur_base  = CMP2_ADDR;
            cur_value = sh_cmp2;
        end
    end

    assign ld_addr    = cur_base + {5'b0, byte_hi};
    assign ld_data    = byte_hi ? cur_value[15:8] : cur_value[7:0];
    assign loader_req = (state == S_LOAD) && (dirty != 3'b000);
    assign grant      = loader_req && !host_act;

    always_comb begin
        dirty_nxt = dirty;
        if (shadow_ld) begin
            dirty_nxt = dirty | ld_mask;
        end
        if (grant && byte_hi) begin
            dirty_nxt = dirty & ~cur_mask;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (commit) begin
`ifdef PWM_SHADOW_SYNC_WRAP_EN
                    state_nxt = S_ARMED;
`else
                    state_nxt = S_LOAD;
`endif
                end
            end
`ifdef PWM_SHADOW_SYNC_WRAP_EN
            S_ARMED: begin
                if (counter_val == 16'h0000) begin
                    state_nxt = S_LOAD;
                end
            end
`endif
            S_LOAD: begin
                // Leave as the final MSB is granted so done follows the last write directly.
                if ((dirty == 3'b000) || (grant && byte_hi && (dirty_nxt == 3'b000))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sh_period <= '0;
            sh_cmp1   <= '0;
            sh_cmp2   <= '0;
            dirty     <= '0;
            byte_hi   <= 1'b0;
        end else begin
            state <= state_nxt;
            dirty <= dirty_nxt;
            if (grant) begin
                byte_hi <= ~byte_hi;
            end
            if (shadow_ld) begin
                case (sh_sel)
                    2'd0:    sh_period <= sh_data;
                    2'd1:    sh_cmp1   <= sh_data;
                    2'd2:    sh_cmp2   <= sh_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        h_data_read = data_read;
        if (host_act) begin
            read       = h_read;
            write      = h_write;
            addr       = h_addr;
            data_write = h_data_write;
        end else begin
            read       = 1'b0;
            write      = loader_req;
            addr       = ld_addr;
            data_write = ld_data;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
